// File: rtl/data_sram_bridge_if.sv
// M-stage access and SRAM-like data port signals of the data_sram_bridge.
// master = the bridge itself, slave = the pipeline/memory side that surrounds it.
interface data_sram_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_en;
    logic                  mem_wr;
    logic [1:0]            mem_size;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  pipe_adv;
    logic                  flush;
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_stall;

    modport master (
        input  mem_en, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
               pipe_adv, flush, data_addr_ok, data_data_ok, data_rdata,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
               mem_rdata, mem_stall
    );

    modport slave (
        output mem_en, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
               pipe_adv, flush, data_addr_ok, data_data_ok, data_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
               mem_rdata, mem_stall
    );
endinterface

// File: rtl/data_sram_bridge.sv
// Single-outstanding bridge from the M stage to the core's SRAM-like data port;
// stalls the pipeline per access and drains transactions killed by flush.
module data_sram_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_sram_bridge_if.master    bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               r_state;
    logic                 r_cancel;
    logic                 r_req;
    logic                 r_wr;
    logic [1:0]           r_size;
    logic [ADDR_W-1:0]    r_addr;
    logic [STRB_W-1:0]    r_wstrb;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata;
    logic                 w_stall;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cancel <= 1'b0;
            r_req    <= 1'b0;
            r_wr     <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_en && !bus.flush) begin
                        r_wr    <= bus.mem_wr;
                        r_size  <= bus.mem_size;
                        r_addr  <= bus.mem_addr;
                        r_wstrb <= bus.mem_wr ? bus.mem_wstrb : '0;
                        r_wdata <= bus.mem_wdata;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A flushed request is never withdrawn; it is drained after addr_ok.
                    if (bus.flush)
                        r_cancel <= 1'b1;
                    if (bus.data_addr_ok) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.data_data_ok) begin
                        if (!r_wr && !r_cancel)
                            r_rdata <= bus.data_rdata;
                        if (r_cancel || bus.flush) begin
                            r_cancel <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_state  <= S_DONE;
                        end
                    end else if (bus.flush) begin
                        r_cancel <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.pipe_adv || bus.flush)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stall = 1'b0;
        if (resetn) begin
            case (r_state)
                S_IDLE:         w_stall = bus.mem_en & ~bus.flush;
                S_REQ, S_WAIT:  w_stall = 1'b1;
                default:        w_stall = 1'b0;
            endcase
        end
    end

    assign bus.data_req   = r_req;
    assign bus.data_wr    = r_wr;
    assign bus.data_size  = r_size;
    assign bus.data_addr  = r_addr;
    assign bus.data_wstrb = r_wstrb;
    assign bus.data_wdata = r_wdata;
    assign bus.mem_rdata  = r_rdata;
    assign bus.mem_stall  = w_stall;
endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge with a mem_rdata scoreboard.
module tb_data_sram_bridge;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;

    data_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.mem_en       = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_size     = 2'd0;
        bus.mem_addr     = '0;
        bus.mem_wstrb    = '0;
        bus.mem_wdata    = '0;
        bus.pipe_adv     = 1'b0;
        bus.flush        = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata);
        bus.mem_en    = 1'b1;
        bus.mem_wr    = wr;
        bus.mem_size  = size;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wstrb;
        bus.mem_wdata = wdata;
    endtask

    // Scoreboard: compare mem_rdata against the oldest pushed expectation.
    task automatic complete(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.mem_rdata, e);
        end
    endtask

    // Only IDLE raises stall combinationally from mem_en in the same cycle.
    task automatic probe_idle(input string tag);
        bus.mem_en = 1'b1;
        settle();
        check({tag, "_idle_stall"}, {31'd0, bus.mem_stall}, 32'd1);
        check({tag, "_idle_req"}, {31'd0, bus.data_req}, 32'd0);
        bus.mem_en = 1'b0;
        settle();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        model_rdata = 32'd0;
        clear_inputs();
        resetn = 1'b0;

        // Reset state; stall must stay low even with mem_en high.
        next();
        bus.mem_en = 1'b1;
        settle();
        check("rst_stall", {31'd0, bus.mem_stall}, 32'd0);
        next();
        check("rst_req", {31'd0, bus.data_req}, 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_addr", bus.data_addr, 32'd0);
        bus.mem_en = 1'b0;
        resetn = 1'b1;
        next();

        // Word load, minimum latency.
        issue(1'b0, 2'd2, 32'h8000_0010, 4'hF, 32'h1111_1111);
        settle();
        check("ld_c0_stall", {31'd0, bus.mem_stall}, 32'd1);
        check("ld_c0_req", {31'd0, bus.data_req}, 32'd0);
        model_rdata = 32'hDEAD_BEEF;
        exp_q.push_back(model_rdata);
        next();
        bus.data_addr_ok = 1'b1;
        settle();
        check("ld_c1_req", {31'd0, bus.data_req}, 32'd1);
        check("ld_c1_addr", bus.data_addr, 32'h8000_0010);
        check("ld_c1_size", {30'd0, bus.data_size}, 32'd2);
        check("ld_c1_wstrb", {28'd0, bus.data_wstrb}, 32'd0);
        check("ld_c1_wr", {31'd0, bus.data_wr}, 32'd0);
        check("ld_c1_stall", {31'd0, bus.mem_stall}, 32'd1);
        next();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hDEAD_BEEF;
        settle();
        check("ld_c2_req", {31'd0, bus.data_req}, 32'd0);
        check("ld_c2_stall", {31'd0, bus.mem_stall}, 32'd1);
        next();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
        settle();
        check("ld_c3_stall", {31'd0, bus.mem_stall}, 32'd0);
        complete("ld_rdata");
        bus.mem_en   = 1'b0;
        bus.pipe_adv = 1'b1;
        next();
        bus.pipe_adv = 1'b0;
        settle();
        check("ld_c4_stall", {31'd0, bus.mem_stall}, 32'd0);

        // Byte store with addr_ok held off for three cycles; inputs change meanwhile.
        issue(1'b1, 2'd0, 32'h8000_0002, 4'b0100, 32'h00AB_0000);
        settle();
        check("st_c0_stall", {31'd0, bus.mem_stall}, 32'd1);
        exp_q.push_back(model_rdata);
        next();
        bus.mem_addr  = 32'h1234_0000;
        bus.mem_wdata = 32'hFFFF_FFFF;
        bus.mem_wstrb = 4'hF;
        for (int unsigned i = 0; i < 3; i++) begin
            settle();
            check("st_wait_req", {31'd0, bus.data_req}, 32'd1);
            check("st_wait_addr", bus.data_addr, 32'h8000_0002);
            check("st_wait_wstrb", {28'd0, bus.data_wstrb}, 32'h4);
            check("st_wait_wdata", bus.data_wdata, 32'h00AB_0000);
            check("st_wait_wr", {31'd0, bus.data_wr}, 32'd1);
            check("st_wait_stall", {31'd0, bus.mem_stall}, 32'd1);
            next();
        end
        bus.data_addr_ok = 1'b1;
        settle();
        check("st_aok_req", {31'd0, bus.data_req}, 32'd1);
        next();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h5555_AAAA;
        settle();
        check("st_dok_req", {31'd0, bus.data_req}, 32'd0);
        next();
        bus.data_data_ok = 1'b0;
        settle();
        check("st_done_stall", {31'd0, bus.mem_stall}, 32'd0);
        complete("st_rdata");
        bus.mem_en   = 1'b0;
        bus.pipe_adv = 1'b1;
        next();
        bus.pipe_adv = 1'b0;

        // Flush while the request is pending: drained, no capture, no DONE.
        issue(1'b0, 2'd2, 32'h8000_0020, 4'hF, 32'd0);
        exp_q.push_back(model_rdata);
        next();
        bus.mem_en = 1'b0;
        bus.flush  = 1'b1;
        settle();
        check("fr_c1_req", {31'd0, bus.data_req}, 32'd1);
        check("fr_c1_stall", {31'd0, bus.mem_stall}, 32'd1);
        next();
        bus.flush        = 1'b0;
        bus.data_addr_ok = 1'b1;
        settle();
        check("fr_c2_req", {31'd0, bus.data_req}, 32'd1);
        next();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1234_5678;
        settle();
        check("fr_c3_req", {31'd0, bus.data_req}, 32'd0);
        check("fr_c3_stall", {31'd0, bus.mem_stall}, 32'd1);
        next();
        bus.data_data_ok = 1'b0;
        settle();
        check("fr_c4_stall", {31'd0, bus.mem_stall}, 32'd0);
        complete("fr_rdata");
        probe_idle("fr");

        // Flush while waiting for data.
        next();
        issue(1'b0, 2'd2, 32'h8000_0030, 4'hF, 32'd0);
        exp_q.push_back(model_rdata);
        next();
        bus.data_addr_ok = 1'b1;
        next();
        bus.data_addr_ok = 1'b0;
        bus.mem_en       = 1'b0;
        bus.flush        = 1'b1;
        settle();
        check("fw_c2_stall", {31'd0, bus.mem_stall}, 32'd1);
        next();
        bus.flush = 1'b0;
        settle();
        check("fw_c3_stall", {31'd0, bus.mem_stall}, 32'd1);
        next();
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hCAFE_F00D;
        settle();
        check("fw_c4_stall", {31'd0, bus.mem_stall}, 32'd1);
        next();
        bus.data_data_ok = 1'b0;
        settle();
        check("fw_c5_stall", {31'd0, bus.mem_stall}, 32'd0);
        complete("fw_rdata");
        probe_idle("fw");

        // Hold in DONE, then a back-to-back access restarted from IDLE.
        next();
        issue(1'b0, 2'd2, 32'h8000_0040, 4'hF, 32'd0);
        model_rdata = 32'hA5A5_1234;
        exp_q.push_back(model_rdata);
        next();
        bus.data_addr_ok = 1'b1;
        next();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hA5A5_1234;
        next();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
        settle();
        complete("hold_rdata");
        for (int unsigned i = 0; i < 4; i++) begin
            settle();
            check("hold_stall", {31'd0, bus.mem_stall}, 32'd0);
            check("hold_req", {31'd0, bus.data_req}, 32'd0);
            check("hold_rdata_kept", bus.mem_rdata, 32'hA5A5_1234);
            next();
        end
        bus.pipe_adv = 1'b1;
        issue(1'b0, 2'd1, 32'h8000_0052, 4'hF, 32'd0);
        next();
        bus.pipe_adv = 1'b0;
        settle();
        check("b2b_idle_stall", {31'd0, bus.mem_stall}, 32'd1);
        check("b2b_idle_req", {31'd0, bus.data_req}, 32'd0);
        model_rdata = 32'h0BAD_F00D;
        exp_q.push_back(model_rdata);
        next();
        bus.data_addr_ok = 1'b1;
        settle();
        check("b2b_req", {31'd0, bus.data_req}, 32'd1);
        check("b2b_addr", bus.data_addr, 32'h8000_0052);
        check("b2b_size", {30'd0, bus.data_size}, 32'd1);
        next();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h0BAD_F00D;
        next();
        bus.data_data_ok = 1'b0;
        settle();
        check("b2b_done_stall", {31'd0, bus.mem_stall}, 32'd0);
        complete("b2b_rdata");
        bus.mem_en   = 1'b0;
        bus.pipe_adv = 1'b1;
        next();
        bus.pipe_adv = 1'b0;

        // Reset in WAIT abandons the store; a later stray data_ok is ignored.
        issue(1'b1, 2'd2, 32'h8000_0060, 4'hF, 32'h7777_8888);
        next();
        bus.data_addr_ok = 1'b1;
        next();
        bus.data_addr_ok = 1'b0;
        resetn = 1'b0;
        settle();
        check("rw_rst_stall", {31'd0, bus.mem_stall}, 32'd0);
        next();
        resetn     = 1'b1;
        bus.mem_en = 1'b0;
        settle();
        check("rw_req", {31'd0, bus.data_req}, 32'd0);
        check("rw_wr", {31'd0, bus.data_wr}, 32'd0);
        check("rw_size", {30'd0, bus.data_size}, 32'd0);
        check("rw_addr", bus.data_addr, 32'd0);
        check("rw_wstrb", {28'd0, bus.data_wstrb}, 32'd0);
        check("rw_wdata", bus.data_wdata, 32'd0);
        check("rw_rdata", bus.mem_rdata, 32'd0);
        check("rw_stall", {31'd0, bus.mem_stall}, 32'd0);
        model_rdata = 32'd0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hFFFF_FFFF;
        next();
        bus.data_data_ok = 1'b0;
        settle();
        check("rw_stray_rdata", bus.mem_rdata, model_rdata);
        check("rw_stray_stall", {31'd0, bus.mem_stall}, 32'd0);
        probe_idle("rw");

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits directly downstream of the M-stage byte-lane/sign-extension logic in the CPU core.
- Takes the lane-aligned write strobe, write data, address and access size, and runs one transaction at a time on the core's SRAM-like data port (req/addr_ok/data_ok).
- Returns the raw 32-bit read word to the M stage, which extracts and sign-extends it.
- Stalls the pipeline until the access completes, and quietly drains any transaction that a flush kills mid-flight.

Parameters:
- ADDR_W, 32, data address width.
- DATA_W, 32, data bus width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- mem_en  in  1  M stage holds a valid load/store this cycle.
- mem_wr  in  1  1 = store, 0 = load.
- mem_size  in  2  0 = byte, 1 = halfword, 2 = word.
- mem_addr  in  ADDR_W  byte address of the access.
- mem_wstrb  in  DATA_W/8  lane-aligned byte write enables.
- mem_wdata  in  DATA_W  lane-aligned store data.
- pipe_adv  in  1  M stage advances this cycle; result is consumed.
- flush  in  1  exception/eret flush; kills the current access.
- data_req  out  1  request valid on the SRAM-like port.
- data_wr  out  1  registered copy of mem_wr.
- data_size  out  2  registered copy of mem_size.
- data_addr  out  ADDR_W  registered copy of mem_addr.
- data_wstrb  out  DATA_W/8  registered copy of mem_wstrb (0 for loads).
- data_wdata  out  DATA_W  registered copy of mem_wdata.
- data_addr_ok  in  1  slave accepts the address phase.
- data_data_ok  in  1  slave completes the data phase.
- data_rdata  in  DATA_W  read data, valid with data_ok.
- mem_rdata  out  DATA_W  raw read word held for the M stage.
- mem_stall  out  1  stall request to the hazard unit.

Behaviour:
- Reset (resetn = 0 at a rising edge):
  - state goes to IDLE and the cancel flag clears.
  - All registered outputs become 0.
  - mem_stall is forced to 0 while resetn is low.
  - Reset mid-transaction abandons it; no drain is attempted.
- FSM states: IDLE, REQ, WAIT, DONE. A cancel flag marks a transaction killed by flush.
- IDLE:
  - data_req = 0.
  - mem_stall = mem_en & ~flush (combinational).
  - If mem_en & ~flush, latch wr/size/addr/wstrb/wdata into the data_* registers (wstrb forced to 0 when mem_wr = 0) and go to REQ.
- REQ:
  - data_req = 1, mem_stall = 1.
  - data_* outputs must stay stable until addr_ok.
  - On data_addr_ok, go to WAIT.
  - A flush in REQ sets cancel. req still stays high until addr_ok; it is never withdrawn.
- WAIT:
  - data_req = 0, mem_stall = 1.
  - On data_data_ok:
    - For a load with cancel = 0, capture data_rdata into mem_rdata.
    - If cancel is set (or flush arrives this cycle), go to IDLE and clear cancel.
    - Otherwise go to DONE.
  - A flush in WAIT without data_ok sets cancel.
- DONE:
  - mem_stall = 0; mem_rdata is held.
  - On pipe_adv or flush, go to IDLE.
  - Otherwise stay, holding the result while other hazards stall M.
- Latency: mem_en at cycle 0 gives data_req at cycle 1. With addr_ok at cycle 1 and data_ok at cycle 2, DONE (stall low) is at cycle 3. Minimum 3 stall cycles per access.
- Back-to-back accesses: DONE → IDLE → REQ, so a new access issues one cycle after pipe_adv. mem_en seen in the same cycle as the DONE exit is ignored; it is restarted from IDLE.
- addr_ok and data_ok together in REQ: treat as addr_ok only. data_ok is only honoured in WAIT, since the slave returns data at least one cycle after addr_ok.
- data_ok in IDLE/REQ/DONE is ignored.
- Stores leave mem_rdata unchanged.
- Only one outstanding transaction; no buffering of a second request.

Test Plan:
- Word load: mem_en=1, mem_wr=0, mem_size=2, addr=0x8000_0010; addr_ok at cycle 1, data_ok at cycle 2 with rdata=0xDEAD_BEEF → req high only at cycle 1, stall high cycles 0–2, mem_rdata=0xDEAD_BEEF at cycle 3.
- Byte store: wstrb=4'b0100, wdata=0x00AB_0000, addr=0x8000_0002; addr_ok delayed 3 cycles → req/addr/wstrb/wdata stable across all 3 wait cycles, data_wr=1, mem_rdata unchanged after completion.
- Flush during REQ: flush at cycle 1, addr_ok at cycle 2, data_ok at cycle 3 with rdata=0x1234_5678 → req held until cycle 2, FSM returns to IDLE at cycle 4, mem_rdata not updated, no DONE state.
- Flush during WAIT: load issued, flush in the cycle after addr_ok, data_ok two cycles later → transaction drained, FSM to IDLE, stall drops while mem_en is low.
- Hold in DONE: load completes, pipe_adv low for 4 cycles → stall=0, mem_rdata held for all 4 cycles, no new req; pipe_adv=1 → IDLE; next mem_en issues req the following cycle.
- Reset mid-WAIT: resetn=0 for one edge → data_req=0, all data_* = 0, mem_rdata=0, state IDLE; a later stray data_ok is ignored.
